// File: rtl/ps2_pkg.sv
// Shared constants, LED FSM state type and the Hack shift-mapping helper
// for the PS/2 keyboard controller.
package ps2_pkg;

    // Raw PS/2 protocol bytes
    localparam logic [7:0] PS2_BREAK   = 8'hF0;
    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_SET_LED = 8'hED;

    // Set-2 scan codes of the modifier keys (all non-extended)
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [2:0] {
        LED_IDLE,
        LED_SEND_CMD,
        LED_WAIT_ACK1,
        LED_SEND_LED,
        LED_WAIT_ACK2
    } led_state_t;

    // Apply Shift / Caps Lock to an unshifted Hack code.
    function automatic logic [7:0] shift_map(input logic [7:0] code,
                                             input logic       shift,
                                             input logic       caps);
        logic [7:0] r;
        r = code;
        if (code >= 8'h61 && code <= 8'h7A) begin
            if (shift ^ caps) r = code - 8'h20;
        end else if (shift) begin
            case (code)
                8'h31: r = 8'h21;  8'h32: r = 8'h40;  8'h33: r = 8'h23;
                8'h34: r = 8'h24;  8'h35: r = 8'h25;  8'h36: r = 8'h5E;
                8'h37: r = 8'h26;  8'h38: r = 8'h2A;  8'h39: r = 8'h28;
                8'h30: r = 8'h29;  8'h2D: r = 8'h5F;  8'h3D: r = 8'h2B;
                8'h5B: r = 8'h7B;  8'h5D: r = 8'h7D;  8'h5C: r = 8'h7C;
                8'h3B: r = 8'h3A;  8'h27: r = 8'h22;  8'h2C: r = 8'h3C;
                8'h2E: r = 8'h3E;  8'h2F: r = 8'h3F;
                default: r = code;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_scancode2hack.sv
// Set-2 scan code to unshifted Hack code translator. Tracks its own E0/F0
// prefixes and emits one registered event per non-prefix byte.
module ps2_scancode2hack
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_code,
    input  logic       rx_valid,
    output logic [7:0] hack,
    output logic       pressed,
    output logic       hack_valid
);

    logic ext_seen;
    logic brk_seen;

    // Unshifted Hack code for a Set-2 code; 0 for anything unmapped.
    function automatic logic [7:0] set2_to_hack(input logic [7:0] c, input logic ext);
        logic [7:0] h;
        h = 8'h00;
        if (ext) begin
            case (c)
                8'h6B: h = 8'd130;  8'h75: h = 8'd131;  8'h74: h = 8'd132;
                8'h72: h = 8'd133;  8'h6C: h = 8'd134;  8'h69: h = 8'd135;
                8'h7D: h = 8'd136;  8'h7A: h = 8'd137;  8'h70: h = 8'd138;
                8'h71: h = 8'd139;  8'h5A: h = 8'd128;
                default: h = 8'h00;
            endcase
        end else begin
            case (c)
                8'h1C: h = "a";  8'h32: h = "b";  8'h21: h = "c";  8'h23: h = "d";
                8'h24: h = "e";  8'h2B: h = "f";  8'h34: h = "g";  8'h33: h = "h";
                8'h43: h = "i";  8'h3B: h = "j";  8'h42: h = "k";  8'h4B: h = "l";
                8'h3A: h = "m";  8'h31: h = "n";  8'h44: h = "o";  8'h4D: h = "p";
                8'h15: h = "q";  8'h2D: h = "r";  8'h1B: h = "s";  8'h2C: h = "t";
                8'h3C: h = "u";  8'h2A: h = "v";  8'h1D: h = "w";  8'h22: h = "x";
                8'h35: h = "y";  8'h1A: h = "z";
                8'h16: h = "1";  8'h1E: h = "2";  8'h26: h = "3";  8'h25: h = "4";
                8'h2E: h = "5";  8'h36: h = "6";  8'h3D: h = "7";  8'h3E: h = "8";
                8'h46: h = "9";  8'h45: h = "0";
                8'h0E: h = 8'h60;  8'h4E: h = 8'h2D;  8'h55: h = 8'h3D;  8'h54: h = 8'h5B;
                8'h5B: h = 8'h5D;  8'h5D: h = 8'h5C;  8'h4C: h = 8'h3B;  8'h52: h = 8'h27;
                8'h41: h = 8'h2C;  8'h49: h = 8'h2E;  8'h4A: h = 8'h2F;  8'h29: h = 8'h20;
                8'h5A: h = 8'd128; 8'h66: h = 8'd129; 8'h76: h = 8'd140;
                8'h05: h = 8'd141; 8'h06: h = 8'd142; 8'h04: h = 8'd143; 8'h0C: h = 8'd144;
                8'h03: h = 8'd145; 8'h0B: h = 8'd146; 8'h83: h = 8'd147; 8'h0A: h = 8'd148;
                8'h01: h = 8'd149; 8'h09: h = 8'd150; 8'h78: h = 8'd151; 8'h07: h = 8'd152;
                default: h = 8'h00;
            endcase
        end
        return h;
    endfunction

    // Prefix tracking and registered translation event
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_seen   <= 1'b0;
            brk_seen   <= 1'b0;
            hack       <= 8'h00;
            pressed    <= 1'b0;
            hack_valid <= 1'b0;
        end else begin
            hack_valid <= 1'b0;
            if (rx_valid) begin
                if (rx_code == PS2_EXT) begin
                    ext_seen <= 1'b1;
                end else if (rx_code == PS2_BREAK) begin
                    brk_seen <= 1'b1;
                end else begin
                    hack       <= set2_to_hack(rx_code, ext_seen);
                    pressed    <= !brk_seen;
                    hack_valid <= 1'b1;
                    ext_seen   <= 1'b0;
                    brk_seen   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: modifier tracking, Hack KBD register, key-event
// FIFO and the Caps Lock LED update handshake with the keyboard.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_code,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_req,
    input  logic       tx_ready,
    output logic [7:0] kbd,
    output logic [7:0] key_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       ovf,
    input  logic       ovf_clr,
    output logic       caps_led,
    output logic       led_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [7:0] hack;
    logic       pressed;
    logic       hack_valid;

    ps2_scancode2hack u_xlate (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_code    (rx_code),
        .rx_valid   (rx_valid),
        .hack       (hack),
        .pressed    (pressed),
        .hack_valid (hack_valid)
    );

    // ---------------- modifiers ----------------
    logic raw_e0, raw_f0, shift_l, shift_r, caps_held;
    logic caps_toggle;

    assign caps_toggle = rx_valid && rx_code == SC_CAPS && !raw_e0 && !raw_f0 && !caps_held;

    // Raw-stream prefix flags and Shift / Caps Lock state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw_e0    <= 1'b0;
            raw_f0    <= 1'b0;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_held <= 1'b0;
            caps_led  <= 1'b0;
        end else if (rx_valid) begin
            if (rx_code == PS2_EXT) begin
                raw_e0 <= 1'b1;
            end else if (rx_code == PS2_BREAK) begin
                raw_f0 <= 1'b1;
            end else begin
                raw_e0 <= 1'b0;
                raw_f0 <= 1'b0;
                if (!raw_e0) begin
                    if (rx_code == SC_LSHIFT) shift_l <= !raw_f0;
                    if (rx_code == SC_RSHIFT) shift_r <= !raw_f0;
                    if (rx_code == SC_CAPS) begin
                        caps_held <= !raw_f0;
                        if (caps_toggle) caps_led <= !caps_led;
                    end
                end
            end
        end
    end

    // ---------------- key events / FIFO ----------------
    logic [7:0]  shifted, kbd_base;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        ev_press, ev_release, fifo_full, push, pop, drop;

    assign shifted    = shift_map(hack, shift_l | shift_r, caps_led);
    assign ev_press   = hack_valid && pressed && hack != 8'h00;
    assign ev_release = hack_valid && !pressed && hack != 8'h00;
    assign fifo_full  = count == (AW+1)'(FIFO_DEPTH);
    assign key_valid  = count != '0;
    assign key_data   = mem[rd_ptr];
    assign pop        = key_valid && key_ready;
    assign push       = ev_press && (!fifo_full || pop);
    assign drop       = ev_press && fifo_full && !pop;

    // FIFO storage
    // NOTE: the storage array has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shifted;
    end

    // FIFO pointers, occupancy, overflow flag and the KBD register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            kbd      <= 8'h00;
            kbd_base <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);

            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;

            if (ev_press) begin
                kbd      <= shifted;
                kbd_base <= hack;
            end else if (ev_release && hack == kbd_base) begin
                kbd <= 8'h00;
            end
        end
    end

    // ---------------- LED update FSM ----------------
    led_state_t    state, next_state;
    logic [TW-1:0] timer;
    logic          led_pending, led_snap, led_start, timed_out;
    logic          rx_ack, rx_nak, expired;

    assign rx_ack  = rx_valid && rx_code == PS2_ACK;
    assign rx_nak  = rx_valid && rx_code == PS2_RESEND;
    assign expired = timer == TW'(TIMEOUT - 1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= LED_IDLE;
        else        state <= next_state;
    end

    // Next state and transmit outputs
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        next_state = state;
        tx_req     = 1'b0;
        tx_data    = 8'h00;
        led_start  = 1'b0;
        timed_out  = 1'b0;
        case (state)
            LED_IDLE: begin
                if (led_pending) begin
                    next_state = LED_SEND_CMD;
                    led_start  = 1'b1;
                end
            end
            LED_SEND_CMD: begin
                tx_req  = 1'b1;
                tx_data = PS2_SET_LED;
                if (tx_ready) next_state = LED_WAIT_ACK1;
            end
            LED_WAIT_ACK1: begin
                if (rx_ack)      next_state = LED_SEND_LED;
                else if (rx_nak) next_state = LED_SEND_CMD;
                else if (expired) begin
                    next_state = LED_IDLE;
                    timed_out  = 1'b1;
                end
            end
            LED_SEND_LED: begin
                tx_req  = 1'b1;
                tx_data = {5'b0, led_snap, 2'b0};
                if (tx_ready) next_state = LED_WAIT_ACK2;
            end
            LED_WAIT_ACK2: begin
                if (rx_ack)      next_state = LED_IDLE;
                else if (rx_nak) next_state = LED_SEND_LED;
                else if (expired) begin
                    next_state = LED_IDLE;
                    timed_out  = 1'b1;
                end
            end
            default: next_state = LED_IDLE;
        endcase
    end

    // ACK timeout counter, reloaded whenever the FSM changes state
    always_ff @(posedge clk) begin
        if (!rst_n)                   timer <= '0;
        else if (next_state != state) timer <= '0;
        else if (state == LED_WAIT_ACK1 || state == LED_WAIT_ACK2) timer <= timer + TW'(1);
    end

    // LED request bookkeeping: a toggle always re-arms, the snapshot keeps tx_data stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_pending <= 1'b0;
            led_snap    <= 1'b0;
            led_err     <= 1'b0;
        end else begin
            if (caps_toggle)    led_pending <= 1'b1;
            else if (led_start) led_pending <= 1'b0;
            if (led_start) led_snap <= caps_led;
            if (timed_out)    led_err <= 1'b1;
            else if (ovf_clr) led_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed self-checking bench for ps2_kbd_ctrl.
module tb_ps2_kbd_ctrl;

    localparam int TMO = 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_code;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ready;
    logic [7:0] kbd;
    logic [7:0] key_data;
    logic       key_valid;
    logic       key_ready;
    logic       ovf;
    logic       ovf_clr;
    logic       caps_led;
    logic       led_err;

    int total = 0;
    int bad   = 0;

    ps2_kbd_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_code(rx_code), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_req(tx_req), .tx_ready(tx_ready), .kbd(kbd),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .ovf(ovf), .ovf_clr(ovf_clr), .caps_led(caps_led), .led_err(led_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rx_code = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        key_ready = 1'b0; ovf_clr = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk); rx_code = b; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        cycles(2);
    endtask

    task automatic pop_one();
        @(negedge clk); key_ready = 1'b1;
        @(negedge clk); key_ready = 1'b0;
    endtask

    task automatic accept_tx();
        @(negedge clk); tx_ready = 1'b1;
        @(negedge clk); tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL rst_tx_req: got %b want 0", tx_req); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        total++; if (kbd !== 8'h00) begin bad++; $display("FAIL rst_kbd: got %h want 00", kbd); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_key_valid: got %b want 0", key_valid); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        total++; if (caps_led !== 1'b0) begin bad++; $display("FAIL rst_caps: got %b want 0", caps_led); end
        total++; if (led_err !== 1'b0) begin bad++; $display("FAIL rst_led_err: got %b want 0", led_err); end
    endtask

    task automatic test_shift_letter();
        do_reset();
        send(8'h12); send(8'h1C);
        total++; if (kbd !== 8'h41) begin bad++; $display("FAIL shift_kbd: got %h want 41", kbd); end
        total++; if (key_valid !== 1'b1 || key_data !== 8'h41) begin bad++; $display("FAIL shift_fifo: got v=%b d=%h want v=1 d=41", key_valid, key_data); end
        send(8'hF0); send(8'h1C);
        total++; if (kbd !== 8'h00) begin bad++; $display("FAIL shift_release_kbd: got %h want 00", kbd); end
        send(8'hF0); send(8'h12);
        pop_one();
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL shift_one_entry: got v=%b want 0", key_valid); end
        send(8'h1C);
        total++; if (key_data !== 8'h61) begin bad++; $display("FAIL unshifted_a: got %h want 61", key_data); end
        pop_one();
        send(8'h59); send(8'h4E);
        total++; if (key_data !== 8'h5F) begin bad++; $display("FAIL rshift_minus: got %h want 5F", key_data); end
        pop_one();
    endtask

    task automatic test_caps_lock();
        do_reset();
        send(8'h58); send(8'h58);
        total++; if (caps_led !== 1'b1) begin bad++; $display("FAIL caps_once: got %b want 1", caps_led); end
        send(8'hF0); send(8'h58);
        total++; if (caps_led !== 1'b1) begin bad++; $display("FAIL caps_break: got %b want 1", caps_led); end
        total++; if (tx_req !== 1'b1 || tx_data !== 8'hED) begin bad++; $display("FAIL caps_tx_cmd: got req=%b data=%h want req=1 data=ED", tx_req, tx_data); end
        send(8'h1C);
        total++; if (key_data !== 8'h41) begin bad++; $display("FAIL caps_letter: got %h want 41", key_data); end
        pop_one();
        send(8'h16);
        total++; if (key_data !== 8'h31) begin bad++; $display("FAIL caps_digit: got %h want 31", key_data); end
        pop_one();
        send(8'h12); send(8'h1C);
        total++; if (key_data !== 8'h61) begin bad++; $display("FAIL caps_shift_letter: got %h want 61", key_data); end
        pop_one();
        send(8'hF0); send(8'h12);
        accept_tx();
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL led_wait1_req: got %b want 0", tx_req); end
        send(8'hFA);
        total++; if (tx_req !== 1'b1 || tx_data !== 8'h04) begin bad++; $display("FAIL led_tx_byte: got req=%b data=%h want req=1 data=04", tx_req, tx_data); end
        accept_tx();
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL led_wait2_req: got %b want 0", tx_req); end
        send(8'hFA);
        cycles(TMO + 5);
        total++; if (tx_req !== 1'b0 || led_err !== 1'b0) begin bad++; $display("FAIL led_done_idle: got req=%b err=%b want req=0 err=0", tx_req, led_err); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ack_not_pushed: got v=%b want 0", key_valid); end
    endtask

    task automatic test_resend_timeout();
        do_reset();
        send(8'h58);
        accept_tx();
        send(8'hFE);
        total++; if (tx_req !== 1'b1 || tx_data !== 8'hED) begin bad++; $display("FAIL resend_cmd: got req=%b data=%h want req=1 data=ED", tx_req, tx_data); end
        accept_tx();
        cycles(TMO - 1);
        total++; if (led_err !== 1'b0) begin bad++; $display("FAIL timeout_early: got err=%b want 0", led_err); end
        cycles(2);
        total++; if (led_err !== 1'b1 || tx_req !== 1'b0) begin bad++; $display("FAIL timeout: got err=%b req=%b want err=1 req=0", led_err, tx_req); end
        cycles(3);
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL timeout_idle: got req=%b want 0", tx_req); end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        total++; if (led_err !== 1'b0) begin bad++; $display("FAIL led_err_clr: got %b want 0", led_err); end
    endtask

    task automatic test_overflow();
        int pops;
        do_reset();
        for (int i = 0; i < 5; i++) send(8'h16);
        total++; if (key_valid !== 1'b1 || key_data !== 8'h31) begin bad++; $display("FAIL ovf_head: got v=%b d=%h want v=1 d=31", key_valid, key_data); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", ovf); end
        // push while full, popping in the same cycle as the translated event
        @(negedge clk); rx_code = 8'h1C; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0; key_ready = 1'b1;
        @(negedge clk); key_ready = 1'b0;
        cycles(2);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL full_push_pop_ovf: got %b want 0", ovf); end
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (key_valid === 1'b1) begin
                total++;
                if (pops < 3 && key_data !== 8'h31) begin bad++; $display("FAIL drain_%0d: got %h want 31", pops, key_data); end
                else if (pops == 3 && key_data !== 8'h61) begin bad++; $display("FAIL drain_last: got %h want 61", key_data); end
                pops++;
                pop_one();
            end
        end
        total++; if (pops !== 4) begin bad++; $display("FAIL full_count: got %0d entries want 4", pops); end
    endtask

    task automatic test_arrow_kbd();
        do_reset();
        send(8'hE0); send(8'h75);
        total++; if (kbd !== 8'd131) begin bad++; $display("FAIL arrow_up: got %0d want 131", kbd); end
        send(8'h1C);
        total++; if (kbd !== 8'h61) begin bad++; $display("FAIL second_key: got %h want 61", kbd); end
        send(8'hE0); send(8'hF0); send(8'h75);
        total++; if (kbd !== 8'h61) begin bad++; $display("FAIL stale_release: got %h want 61", kbd); end
        send(8'hF0); send(8'h1C);
        total++; if (kbd !== 8'h00) begin bad++; $display("FAIL held_release: got %h want 00", kbd); end
        send(8'hE0); send(8'h12); send(8'h1C);
        total++; if (kbd !== 8'h61) begin bad++; $display("FAIL fake_shift_ignored: got %h want 61", kbd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6];
        seq[0] = 8'h12; seq[1] = 8'h15; seq[2] = 8'hF0; seq[3] = 8'h12; seq[4] = 8'h15; seq[5] = 8'h00;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); rx_code = seq[i]; rx_valid = 1'b1;
        end
        @(negedge clk); rx_valid = 1'b0;
        cycles(3);
        total++; if (key_data !== 8'h51) begin bad++; $display("FAIL b2b_first: got %h want 51", key_data); end
        pop_one();
        total++; if (key_valid !== 1'b1 || key_data !== 8'h71) begin bad++; $display("FAIL b2b_second: got v=%b d=%h want v=1 d=71", key_valid, key_data); end
        pop_one();
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h58);
        total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL mid_req_before: got %b want 1", tx_req); end
        do_reset();
        cycles(5);
        total++; if (tx_req !== 1'b0 || caps_led !== 1'b0) begin bad++; $display("FAIL mid_reset: got req=%b caps=%b want 0 0", tx_req, caps_led); end
    endtask

    initial begin
        test_reset();
        test_shift_letter();
        test_caps_lock();
        test_resend_timeout();
        test_overflow();
        test_arrow_kbd();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
